button_combo_lock: RTL and testbench

//  Downstream consumer of the debounced keypad stage. Takes one-cycle key-press events
//  (2-bit key index) and checks them against a fixed SEQ_LEN-key combination.

---
 rtl/button_combo_lock_pkg.sv | 42 ++++
 rtl/button_combo_lock_seg7_decode.sv | 26 ++
 rtl/button_combo_lock.sv | 162 ++++++++++++++++
 tb/tb_button_combo_lock.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/button_combo_lock_pkg.sv
// Shared definitions for the combination lock: FSM states, segment patterns and the
// LED progress helper.
package button_combo_lock_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StEntry   = 3'd1,
        StOpen    = 3'd2,
        StFail    = 3'd3,
        StLockout = 3'd4
    } state_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_E    = 7'b0000110;
    localparam logic [6:0] SEG_L    = 7'b1000111;
    localparam logic [6:0] SEG_U    = 7'b1000001;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;

    localparam logic [7:0] LEDS_OFF     = 8'h00;
    localparam logic [7:0] LEDS_OPEN    = 8'hFF;
    localparam logic [7:0] LEDS_LOCKOUT = 8'h81;

    // LEDs[i] lit for every i below n
    function automatic logic [7:0] thermometer(input logic [3:0] n);
        logic [7:0] t;
        for (int i = 0; i < 8; i++) begin
            t[i] = (4'(i) < n);
        end
        return t;
    endfunction

endpackage

// File: rtl/button_combo_lock_seg7_decode.sv
// Combinational 4-bit digit to active-low 7-segment decoder; codes above 9 show a dash.
module button_combo_lock_seg7_decode
    import button_combo_lock_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (digit_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/button_combo_lock.sv
// Keypad combination lock: checks SEQ_LEN key events against CODE, with entry timeout,
// fail display, lockout after repeated failures and a timed unlock strobe.
module button_combo_lock
    import button_combo_lock_pkg::*;
#(
    parameter int unsigned SEQ_LEN        = 4,
    parameter logic [15:0] CODE           = 16'b0000_0000_0011_0110,
    parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
    parameter int unsigned OPEN_CYCLES    = 200_000_000,
    parameter int unsigned FAIL_CYCLES    = 100_000_000,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       press_valid,
    input  logic [1:0] press_code,
    output logic [7:0] LEDs,
    output logic [6:0] S,
    output logic       signalout
);

    localparam logic [3:0] SeqLenW   = 4'(SEQ_LEN);
    localparam logic [3:0] MaxFailsW = 4'(MAX_FAILS);

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        mismatch_q, mismatch_d;
    logic [3:0]  fail_cnt_q, fail_cnt_d;
    logic [31:0] timer_q, timer_d;

    logic [1:0]  key_exp;
    logic        press_mismatch;
    logic [3:0]  press_count;
    logic [7:0]  leds_d;
    logic [6:0]  seg_d;
    logic [6:0]  count_seg;

    // Expected key for the press about to be accepted (count_q is 0 in IDLE)
    assign key_exp        = 2'(CODE >> {count_q, 1'b0});
    assign press_mismatch = mismatch_q | (press_code != key_exp);
    assign press_count    = count_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
        fail_cnt_d = fail_cnt_q;
        timer_d    = timer_q + 32'd1;

        case (state_q)
            StIdle, StEntry: begin
                if (press_valid) begin
                    timer_d = '0;
                    if (press_count == SeqLenW) begin
                        count_d    = '0;
                        mismatch_d = 1'b0;
                        if (press_mismatch) begin
                            state_d    = StFail;
                            fail_cnt_d = fail_cnt_q + 4'd1;
                        end else begin
                            state_d    = StOpen;
                            fail_cnt_d = '0;
                        end
                    end else begin
                        state_d    = StEntry;
                        count_d    = press_count;
                        mismatch_d = press_mismatch;
                    end
                end else if (state_q == StIdle) begin
                    timer_d = '0;
                end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
                    state_d    = StIdle;
                    count_d    = '0;
                    mismatch_d = 1'b0;
                    timer_d    = '0;
                end
            end
            StOpen: begin
                if (timer_q == OPEN_CYCLES - 32'd1) begin
                    state_d = StIdle;
                    timer_d = '0;
                end
            end
            StFail: begin
                if (timer_q == FAIL_CYCLES - 32'd1) begin
                    state_d = (fail_cnt_q == MaxFailsW) ? StLockout : StIdle;
                    timer_d = '0;
                end
            end
            StLockout: begin
                if (timer_q == LOCKOUT_CYCLES - 32'd1) begin
                    state_d    = StIdle;
                    fail_cnt_d = '0;
                    timer_d    = '0;
                end
            end
            default: begin
                state_d    = StIdle;
                count_d    = '0;
                mismatch_d = 1'b0;
                timer_d    = '0;
            end
        endcase
    end

    button_combo_lock_seg7_decode u_seg7 (
        .digit_i (count_d),
        .seg_o   (count_seg)
    );

    // Outputs decode the next state so they register in the same edge as the state
    always_comb begin
        leds_d = LEDS_OFF;
        seg_d  = SEG_DASH;
        case (state_d)
            StEntry: begin
                leds_d = thermometer(count_d);
                seg_d  = count_seg;
            end
            StOpen: begin
                leds_d = LEDS_OPEN;
                seg_d  = SEG_U;
            end
            StFail: begin
                leds_d = LEDS_OFF;
                seg_d  = SEG_E;
            end
            StLockout: begin
                leds_d = LEDS_LOCKOUT;
                seg_d  = SEG_L;
            end
            default: begin
                leds_d = LEDS_OFF;
                seg_d  = SEG_DASH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            fail_cnt_q <= '0;
            timer_q    <= '0;
            LEDs       <= LEDS_OFF;
            S          <= SEG_DASH;
            signalout  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            fail_cnt_q <= fail_cnt_d;
            timer_q    <= timer_d;
            LEDs       <= leds_d;
            S          <= seg_d;
            signalout  <= (state_d == StOpen);
        end
    end

endmodule

// File: tb/tb_button_combo_lock.sv
// Self-checking bench for button_combo_lock: directed scenarios plus random key traffic,
// compared every cycle against a queue-based model of the lock.
module tb_button_combo_lock;

    localparam int SEQ  = 4;
    localparam int TMO  = 50;
    localparam int OPN  = 20;
    localparam int FLC  = 10;
    localparam int LCK  = 40;
    localparam int MAXF = 3;

    localparam logic [6:0] DASH = 7'b0111111;
    localparam logic [6:0] LET_E = 7'b0000110;
    localparam logic [6:0] LET_L = 7'b1000111;
    localparam logic [6:0] LET_U = 7'b1000001;

    logic       clk = 1'b0;
    logic       rst;
    logic       press_valid;
    logic [1:0] press_code;
    logic [7:0] LEDs;
    logic [6:0] S;
    logic       signalout;

    always #5 clk = ~clk;

    button_combo_lock #(
        .SEQ_LEN        (SEQ),
        .CODE           (16'b0000_0000_0011_0110),
        .TIMEOUT_CYCLES (TMO),
        .OPEN_CYCLES    (OPN),
        .FAIL_CYCLES    (FLC),
        .MAX_FAILS      (MAXF),
        .LOCKOUT_CYCLES (LCK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .press_valid (press_valid),
        .press_code  (press_code),
        .LEDs        (LEDs),
        .S           (S),
        .signalout   (signalout)
    );

    int         code_keys [SEQ] = '{2, 1, 3, 0};
    logic [6:0] digit_seg [9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                  7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                  7'b0000000};

    int tests = 0;
    int fails = 0;

    // Model: 0 idle, 1 entering, 2 open, 3 fail shown, 4 locked out
    int mode;
    int keys[$];
    int quiet;
    int left;
    int nfail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        mode  = 0;
        keys.delete();
        quiet = 0;
        left  = 0;
        nfail = 0;
    endfunction

    function automatic void model_step(input bit v, input int c);
        bit ok;
        case (mode)
            0, 1: begin
                if (v) begin
                    keys.push_back(c);
                    quiet = 0;
                    if (keys.size() == SEQ) begin
                        ok = 1'b1;
                        for (int i = 0; i < SEQ; i++) if (keys[i] != code_keys[i]) ok = 1'b0;
                        keys.delete();
                        if (ok) begin
                            mode = 2; left = OPN; nfail = 0;
                        end else begin
                            mode = 3; left = FLC; nfail++;
                        end
                    end else begin
                        mode = 1;
                    end
                end else if (mode == 1) begin
                    quiet++;
                    if (quiet == TMO) begin
                        mode = 0;
                        keys.delete();
                    end
                end
            end
            2: begin
                left--;
                if (left == 0) mode = 0;
            end
            3: begin
                left--;
                if (left == 0) begin
                    if (nfail == MAXF) begin
                        mode = 4; left = LCK;
                    end else begin
                        mode = 0;
                    end
                end
            end
            default: begin
                left--;
                if (left == 0) begin
                    mode = 0; nfail = 0;
                end
            end
        endcase
    endfunction

    task automatic compare_all();
        logic [7:0] e_leds;
        logic [6:0] e_seg;
        logic       e_sig;
        e_sig = 1'b0;
        case (mode)
            0: begin e_leds = 8'h00; e_seg = DASH; end
            1: begin e_leds = 8'((1 << keys.size()) - 1); e_seg = digit_seg[keys.size()]; end
            2: begin e_leds = 8'hFF; e_seg = LET_U; e_sig = 1'b1; end
            3: begin e_leds = 8'h00; e_seg = LET_E; end
            default: begin e_leds = 8'h81; e_seg = LET_L; end
        endcase
        check("leds", 32'(LEDs), 32'(e_leds));
        check("seg", 32'(S), 32'(e_seg));
        check("signalout", 32'(signalout), 32'(e_sig));
    endtask

    // Called at a negedge: drive inputs, advance the model, compare at the next negedge
    task automatic cycle(input bit v, input int c);
        press_valid = v;
        press_code  = v ? 2'(c) : 2'($urandom);
        model_step(v, c);
        @(negedge clk);
        compare_all();
    endtask

    task automatic enter(input int k0, input int k1, input int k2, input int k3);
        cycle(1'b1, k0);
        cycle(1'b1, k1);
        cycle(1'b1, k2);
        cycle(1'b1, k3);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0);
    endtask

    task automatic async_reset();
        press_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_leds", 32'(LEDs), 32'h00);
        check("async_rst_seg", 32'(S), 32'(DASH));
        check("async_rst_sig", 32'(signalout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt;
        int r;
        int k;
        rst         = 1'b1;
        press_valid = 1'b0;
        press_code  = 2'd0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_leds", 32'(LEDs), 32'h00);
        check("reset_seg", 32'(S), 32'(DASH));
        check("reset_sig", 32'(signalout), 32'h0);
        rst = 1'b0;

        // Correct code: progress display, then a 20-cycle unlock
        cycle(1'b1, 2);
        check("p1_leds", 32'(LEDs), 32'h01);
        check("p1_seg", 32'(S), 32'(7'b1111001));
        cycle(1'b1, 1);
        check("p2_leds", 32'(LEDs), 32'h03);
        check("p2_seg", 32'(S), 32'(7'b0100100));
        cycle(1'b1, 3);
        check("p3_leds", 32'(LEDs), 32'h07);
        check("p3_seg", 32'(S), 32'(7'b0110000));
        cycle(1'b1, 0);
        check("open_seg", 32'(S), 32'(LET_U));
        cnt = int'(signalout);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 0);
            cnt += int'(signalout);
        end
        check("open_len", 32'(cnt), 32'd20);

        // Wrong code: no early hint, then 10 cycles of E
        cycle(1'b1, 2);
        cycle(1'b1, 0);
        cycle(1'b1, 3);
        check("wrong_no_hint", 32'(LEDs), 32'h07);
        cycle(1'b1, 0);
        cnt = int'(S == LET_E);
        for (int i = 0; i < 15; i++) begin
            cycle(1'b0, 0);
            cnt += int'(S == LET_E);
        end
        check("fail_len", 32'(cnt), 32'd10);

        // Two more failures reach lockout; presses during fail/lockout are dropped
        enter(1, 1, 1, 1);
        idle(15);
        enter(3, 3, 3, 3);
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cycle(($urandom % 3) == 0, int'($urandom % 4));
            cnt += int'(LEDs == 8'h81);
        end
        check("lockout_len", 32'(cnt), 32'd40);
        check("after_lockout_seg", 32'(S), 32'(DASH));
        enter(2, 1, 3, 0);
        check("open_after_lockout", 32'(signalout), 32'h1);
        idle(25);

        // Entry timeout, and a press on the timeout cycle winning
        cycle(1'b1, 2);
        idle(49);
        check("tmo_still_entry", 32'(LEDs), 32'h01);
        idle(1);
        check("tmo_leds", 32'(LEDs), 32'h00);
        check("tmo_seg", 32'(S), 32'(DASH));
        cycle(1'b1, 2);
        idle(49);
        cycle(1'b1, 1);
        check("tmo_press_wins", 32'(LEDs), 32'h03);
        idle(55);

        // A successful open clears the failure count
        enter(0, 0, 0, 0); idle(12);
        enter(0, 0, 0, 0); idle(12);
        enter(2, 1, 3, 0); idle(22);
        enter(0, 0, 0, 0); idle(12);
        enter(0, 0, 0, 0);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 0);
            cnt += int'(LEDs == 8'h81);
        end
        check("no_lockout", 32'(cnt), 32'd0);

        // Asynchronous reset during OPEN and during ENTRY
        enter(2, 1, 3, 0);
        idle(5);
        async_reset();
        idle(3);
        cycle(1'b1, 2);
        cycle(1'b1, 1);
        async_reset();
        idle(3);

        // Random traffic biased towards the correct code
        for (int n = 0; n < 2500; n++) begin
            r = int'($urandom % 1000);
            if (r < 40) begin
                idle(int'($urandom_range(40, 60)));
            end else if (r < 42) begin
                async_reset();
            end else if (r < 350) begin
                k = (($urandom % 2) == 0 && keys.size() < SEQ) ? code_keys[keys.size()]
                                                                : int'($urandom % 4);
                cycle(1'b1, k);
            end else begin
                cycle(1'b0, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
